// File: rtl/washer_pkg.sv
// Shared types and defaults for the washing-machine controller.
// State encoding is fixed because it is exported on the state output.
package washer_pkg;

  typedef enum logic [2:0] {
    IDLE  = 3'd0,
    FILL  = 3'd1,
    WASH  = 3'd2,
    RINSE = 3'd3,
    SPIN  = 3'd4
  } state_e;

  localparam int unsigned DEF_BASE_CYCLES = 1000000;
  localparam int unsigned DEF_FILL_T      = 120;
  localparam int unsigned DEF_WASH_T      = 300;
  localparam int unsigned DEF_RINSE_T     = 120;
  localparam int unsigned DEF_SPIN_T      = 60;

  // Largest clk_freq multiplier is 8x, i.e. a left shift by 3.
  localparam int unsigned FREQ_MAX_SHIFT  = 3;

  // Longest timed-state duration, used to size the seconds counter.
  function automatic int unsigned max_dur(input int unsigned a, input int unsigned b,
                                          input int unsigned c, input int unsigned d);
    int unsigned m;
    m = a;
    if (b > m) m = b;
    if (c > m) m = c;
    if (d > m) m = d;
    return m;
  endfunction

endpackage

// File: rtl/sec_tick_gen.sv
// One-second tick generator. Counts 0..(BASE_CYCLES<<freq_q)-1 and pulses
// sec_tick on the terminal count. clear forces the count to 0; hold freezes
// it and suppresses the tick.
module sec_tick_gen
  import washer_pkg::*;
#(
  parameter int unsigned BASE_CYCLES = DEF_BASE_CYCLES
) (
  input  logic       CLK,
  input  logic       RST,
  input  logic [1:0] freq_q,
  input  logic       clear,
  input  logic       hold,
  output logic       sec_tick
);

  // Wide enough for the 8x terminal count without truncation.
  localparam int unsigned CW = $clog2(BASE_CYCLES << FREQ_MAX_SHIFT);
  localparam int unsigned LW = CW + 1;

  logic [CW-1:0] cnt_q, cnt_d, term;
  logic [LW-1:0] limit;

  // Terminal count, tick decode and next count value.
  always_comb begin
    limit    = LW'(BASE_CYCLES) << freq_q;
    term     = CW'(limit - LW'(1));
    sec_tick = (cnt_q == term) && !hold;
    cnt_d    = cnt_q;
    if (clear) begin
      cnt_d = '0;
    end else if (hold) begin
      cnt_d = cnt_q;
    end else if (cnt_q == term) begin
      cnt_d = '0;
    end else begin
      cnt_d = cnt_q + CW'(1);
    end
  end

  // Cycle counter register.
  always_ff @(posedge CLK or posedge RST) begin
    if (RST) cnt_q <= '0;
    else     cnt_q <= cnt_d;
  end

endmodule

// File: rtl/washer_ctrl.sv
// Washing-machine sequencer: IDLE -> FILL -> WASH -> RINSE -> SPIN -> IDLE.
// Each timed state lasts its duration in seconds, where a second is
// BASE_CYCLES<<freq_q clocks with freq_q captured at the coin.
// Optional feature macro: WASHER_DOUBLE_WASH_EN enables a second WASH+RINSE
// pass when double_wash is high at the coin; otherwise double_wash is ignored.
module washer_ctrl
  import washer_pkg::*;
#(
  parameter int unsigned BASE_CYCLES = DEF_BASE_CYCLES,
  parameter int unsigned FILL_T      = DEF_FILL_T,
  parameter int unsigned WASH_T      = DEF_WASH_T,
  parameter int unsigned RINSE_T     = DEF_RINSE_T,
  parameter int unsigned SPIN_T      = DEF_SPIN_T
) (
  input  logic       CLK,
  input  logic       RST,
  input  logic [1:0] clk_freq,
  input  logic       coin_in,
  input  logic       double_wash,
  input  logic       timer_pause,
  output logic [2:0] state,
  output logic       water_valve,
  output logic       motor_on,
  output logic       busy,
  output logic       wash_done
);

  localparam int unsigned MAX_T = max_dur(FILL_T, WASH_T, RINSE_T, SPIN_T);
  localparam int unsigned SW    = (MAX_T > 1) ? $clog2(MAX_T) : 1;

  state_e        state_q, state_d;
  logic [1:0]    freq_q, freq_d;
  logic          dbl_q, dbl_d;
  logic          pass2_q, pass2_d;
  logic          done_q, done_d;
  logic [SW-1:0] sec_cnt_q, sec_cnt_d;
  logic [SW-1:0] dur_m1;
  logic          sec_tick, tick_clear, tick_hold, last_sec;
  logic          dbl_req;

`ifdef WASHER_DOUBLE_WASH_EN
  assign dbl_req = double_wash;
`else
  logic unused_double_wash;
  assign unused_double_wash = double_wash;
  assign dbl_req            = 1'b0;
`endif

  sec_tick_gen #(.BASE_CYCLES(BASE_CYCLES)) u_tick (
    .CLK      (CLK),
    .RST      (RST),
    .freq_q   (freq_q),
    .clear    (tick_clear),
    .hold     (tick_hold),
    .sec_tick (sec_tick)
  );

  // Final-second detection for the current timed state.
  always_comb begin
    dur_m1 = '0;
    case (state_q)
      FILL:    dur_m1 = SW'(FILL_T - 1);
      WASH:    dur_m1 = SW'(WASH_T - 1);
      RINSE:   dur_m1 = SW'(RINSE_T - 1);
      SPIN:    dur_m1 = SW'(SPIN_T - 1);
      default: dur_m1 = '0;
    endcase
    last_sec = sec_tick && (sec_cnt_q == dur_m1);
  end

  // Next state, captured configuration and completion pulse.
  always_comb begin
    state_d = state_q;
    freq_d  = freq_q;
    dbl_d   = dbl_q;
    pass2_d = pass2_q;
    done_d  = 1'b0;
    case (state_q)
      IDLE: if (coin_in) begin
        state_d = FILL;
        freq_d  = clk_freq;
        dbl_d   = dbl_req;
        pass2_d = 1'b0;
      end
      FILL:  if (last_sec) state_d = WASH;
      WASH:  if (last_sec) state_d = RINSE;
      RINSE: if (last_sec) begin
        if (dbl_q && !pass2_q) begin
          state_d = WASH;
          pass2_d = 1'b1;
        end else begin
          state_d = SPIN;
        end
      end
      SPIN: if (last_sec) begin
        state_d = IDLE;
        done_d  = 1'b1;
      end
      default: state_d = IDLE;
    endcase
  end

  // Counters clear on every transition and stay at 0 in IDLE; pause freezes SPIN only.
  always_comb begin
    tick_hold  = (state_q == SPIN) && timer_pause;
    tick_clear = (state_q == IDLE) || (state_d != state_q);
    sec_cnt_d  = sec_cnt_q;
    if (tick_clear)    sec_cnt_d = '0;
    else if (sec_tick) sec_cnt_d = sec_cnt_q + SW'(1);
  end

  // Control registers.
  always_ff @(posedge CLK or posedge RST) begin
    if (RST) begin
      state_q   <= IDLE;
      freq_q    <= 2'b00;
      dbl_q     <= 1'b0;
      pass2_q   <= 1'b0;
      done_q    <= 1'b0;
      sec_cnt_q <= '0;
    end else begin
      state_q   <= state_d;
      freq_q    <= freq_d;
      dbl_q     <= dbl_d;
      pass2_q   <= pass2_d;
      done_q    <= done_d;
      sec_cnt_q <= sec_cnt_d;
    end
  end

  assign state       = state_q;
  assign water_valve = (state_q == FILL);
  assign motor_on    = (state_q == WASH) || (state_q == RINSE) ||
                       ((state_q == SPIN) && !timer_pause);
  assign busy        = (state_q != IDLE);
  assign wash_done   = done_q;

endmodule

// File: tb/tb_washer_ctrl.sv
// Bench for washer_ctrl with small timing parameters. The reference model is
// a queue of (state, cycles) segments built when a coin is accepted; pause
// cycles in SPIN do not consume the segment. Honors WASHER_DOUBLE_WASH_EN.
module tb_washer_ctrl;

  localparam int BASE = 4;
  localparam int FT   = 2;
  localparam int WT   = 3;
  localparam int RT   = 2;
  localparam int ST   = 1;
`ifdef WASHER_DOUBLE_WASH_EN
  localparam bit DBL_EN = 1'b1;
`else
  localparam bit DBL_EN = 1'b0;
`endif

  logic       CLK = 1'b0;
  logic       RST = 1'b1;
  logic [1:0] clk_freq = 2'b00;
  logic       coin_in = 1'b0;
  logic       double_wash = 1'b0;
  logic       timer_pause = 1'b0;
  logic [2:0] state;
  logic       water_valve, motor_on, busy, wash_done;

  int   checks = 0;
  int   errors = 0;
  int   cyc = 0;
  int   seg_st[$];
  int   seg_len[$];
  logic exp_done = 1'b0;
  int   done_cyc = -1;

  washer_ctrl #(
    .BASE_CYCLES(BASE), .FILL_T(FT), .WASH_T(WT), .RINSE_T(RT), .SPIN_T(ST)
  ) dut (
    .CLK(CLK), .RST(RST), .clk_freq(clk_freq), .coin_in(coin_in),
    .double_wash(double_wash), .timer_pause(timer_pause), .state(state),
    .water_valve(water_valve), .motor_on(motor_on), .busy(busy),
    .wash_done(wash_done)
  );

  // Clock
  always #5 CLK = ~CLK;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    assert (got === exp) else begin
      errors++;
      $error("FAIL %s at cycle %0d: got=%0d expected=%0d", tag, cyc, got, exp);
    end
  endtask

  // One clock: drive inputs, compare outputs with the model, advance model.
  task automatic step(input logic c, input logic p, input logic [1:0] f, input logic dw);
    int es;
    int ld;
    @(posedge CLK); #1;
    coin_in = c; timer_pause = p; clk_freq = f; double_wash = dw;
    #1;
    es = (seg_st.size() > 0) ? seg_st[0] : 0;
    check("state", state, es);
    check("water_valve", water_valve, es == 1);
    check("motor_on", motor_on, (es == 2) || (es == 3) || ((es == 4) && !p));
    check("busy", busy, es != 0);
    check("wash_done", wash_done, exp_done);
    if (wash_done === 1'b1) done_cyc = cyc;
    exp_done = 1'b0;
    if (seg_st.size() == 0) begin
      if (c) begin
        ld = BASE << f;
        seg_st.push_back(1); seg_len.push_back(FT * ld);
        seg_st.push_back(2); seg_len.push_back(WT * ld);
        seg_st.push_back(3); seg_len.push_back(RT * ld);
        if (DBL_EN && dw) begin
          seg_st.push_back(2); seg_len.push_back(WT * ld);
          seg_st.push_back(3); seg_len.push_back(RT * ld);
        end
        seg_st.push_back(4); seg_len.push_back(ST * ld);
      end
    end else if (!((seg_st[0] == 4) && p)) begin
      seg_len[0]--;
      if (seg_len[0] == 0) begin
        if (seg_st[0] == 4) exp_done = 1'b1;
        void'(seg_st.pop_front());
        void'(seg_len.pop_front());
      end
    end
    cyc++;
  endtask

  // Full cycle from a coin; pause p_len cycles starting p_at cycles into SPIN.
  task automatic run_wash(input logic [1:0] f, input logic dw, input int p_at, input int p_len,
                          input bit wash_noise, input bit chg);
    int start, exp_total, units, spin_k, n, es;
    logic p, c, dd;
    logic [1:0] fd;
    done_cyc = -1;
    step(1'b1, 1'b0, f, dw);
    start = cyc;
    units = FT + WT + RT + ST + ((DBL_EN && dw) ? (WT + RT) : 0);
    exp_total = units * (BASE << f) + p_len;
    spin_k = 0;
    n = 0;
    while (done_cyc < 0 && n < 2000) begin
      es = (seg_st.size() > 0) ? seg_st[0] : 0;
      p = 1'b0;
      if (es == 4) begin
        p = (spin_k >= p_at) && (spin_k < p_at + p_len);
        spin_k++;
      end else if (es == 2 && wash_noise) begin
        p = 1'($urandom_range(0, 1));
      end
      fd = chg ? 2'($urandom_range(0, 3)) : f;
      dd = 1'($urandom_range(0, 1));
      c  = (es != 0) ? 1'($urandom_range(0, 1)) : 1'b0;
      step(c, p, fd, dd);
      n++;
    end
    check("done_in_budget", done_cyc >= 0, 1);
    check("cycles_to_done", done_cyc - start, exp_total);
    repeat (3) step(1'b0, 1'b0, 2'($urandom_range(0, 3)), 1'b0);
  endtask

  initial begin
    // Reset state
    #2;
    check("rst_state", state, 0);
    check("rst_valve", water_valve, 0);
    check("rst_motor", motor_on, 0);
    check("rst_busy", busy, 0);
    check("rst_done", wash_done, 0);
    @(negedge CLK);
    RST = 1'b0;
    repeat (3) step(1'b0, 1'b0, 2'b00, 1'b0);

    // Single pass at 1x: 32 cycles
    run_wash(2'b00, 1'b0, 0, 0, 1'b0, 1'b0);
    // 8x with clk_freq churn after the coin: 256 cycles
    run_wash(2'b11, 1'b0, 0, 0, 1'b0, 1'b1);
    // Double wash request: 52 cycles when enabled, 32 otherwise
    run_wash(2'b00, 1'b1, 0, 0, 1'b0, 1'b0);
    // 10-cycle pause in SPIN: 42 cycles; random pause in WASH has no effect
    run_wash(2'b00, 1'b0, 1, 10, 1'b1, 1'b0);
    // Randomized runs
    for (int i = 0; i < 6; i++) begin
      run_wash(2'($urandom_range(0, 3)), 1'($urandom_range(0, 1)),
               int'($urandom_range(0, 3)), int'($urandom_range(0, 12)), 1'b1, 1'b1);
    end

    // Reset mid-WASH abandons the cycle
    step(1'b1, 1'b0, 2'b00, 1'b0);
    repeat (FT * BASE + 3) step(1'b0, 1'b0, 2'b00, 1'b0);
    @(posedge CLK); #3;
    check("pre_reset_wash", state, 2);
    RST = 1'b1;
    #1;
    check("async_rst_state", state, 0);
    check("async_rst_valve", water_valve, 0);
    check("async_rst_motor", motor_on, 0);
    check("async_rst_busy", busy, 0);
    check("async_rst_done", wash_done, 0);
    seg_st.delete();
    seg_len.delete();
    exp_done = 1'b0;
    @(negedge CLK);
    RST = 1'b0;
    repeat (40) step(1'b0, 1'b0, 2'b00, 1'b0);

    // Normal operation after reset
    run_wash(2'b01, 1'b0, 2, 5, 1'b1, 1'b1);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

// File: doc/washer_ctrl.md
WASHER_CTRL -- requirements
Module: washer_ctrl

Interface
REQ-001 Parameter BASE_CYCLES, default 1000000: CLK cycles per second when clk_freq=2'b00 (1 MHz).
REQ-002 Parameter FILL_T, default 120: FILL duration, seconds.
REQ-003 Parameter WASH_T, default 300: WASH duration, seconds.
REQ-004 Parameter RINSE_T, default 120: RINSE duration, seconds.
REQ-005 Parameter SPIN_T, default 60: SPIN duration, seconds.
REQ-006 CLK  in  1  system clock, i.e. the muxed clock; one clock, all logic on rising edge.
REQ-007 RST  in  1  reset, asynchronous, active-high.
REQ-008 clk_freq  in  2  current CLK rate: 00=1x, 01=2x, 10=4x, 11=8x BASE_CYCLES per second.
REQ-009 coin_in  in  1  start request, level-sampled in IDLE.
REQ-010 double_wash  in  1  request a second WASH+RINSE pass.
REQ-011 timer_pause  in  1  pause request, honoured in SPIN only.
REQ-012 state  out  3  current state encoding.
REQ-013 water_valve  out  1  high in FILL.
REQ-014 motor_on  out  1  high in WASH, RINSE, SPIN (unpaused).
REQ-015 busy  out  1  high in any state except IDLE.
REQ-016 wash_done  out  1  one-cycle pulse at cycle completion.

Function
REQ-017 The FSM SHALL have states IDLE=0, FILL=1, WASH=2, RINSE=3, SPIN=4; codes 5-7 SHALL go to IDLE next cycle.
REQ-018 In IDLE with coin_in=1, the block SHALL enter FILL next cycle and latch clk_freq into freq_q and double_wash into dbl_q.
REQ-019 coin_in outside IDLE SHALL be ignored; clk_freq and double_wash changes SHALL be ignored until the next IDLE->FILL.
REQ-020 Tick generator SHALL count 0..(BASE_CYCLES<<freq_q)-1 and pulse sec_tick for one cycle at the terminal count, then wrap to 0.
REQ-021 Tick and second counters SHALL clear on every state transition and hold 0 in IDLE.
REQ-022 The block SHALL leave a timed state on the cycle sec_tick=1 with sec_cnt=DUR-1 (DUR = that state's parameter).
REQ-023 Sequence SHALL be FILL->WASH->RINSE->SPIN->IDLE; exactly DUR*(BASE_CYCLES<<freq_q) cycles spent per timed state.
REQ-024 With dbl_q=1, the first RINSE exit SHALL go to WASH (second pass); second RINSE exit goes to SPIN.
REQ-025 In SPIN with timer_pause=1, tick and second counters SHALL freeze and motor_on SHALL be 0; counting resumes from the frozen value when released.
REQ-026 timer_pause in other states SHALL have no effect.
REQ-027 wash_done SHALL pulse on the cycle state becomes IDLE from SPIN; never otherwise.
REQ-028 Outputs water_valve, motor_on, busy SHALL be decoded from registered state (no input-to-output combinational path except timer_pause->motor_on in SPIN).
REQ-029 Counter widths SHALL be sized from parameters ($clog2) with no truncation at freq_q=11.

Reset
REQ-030 RST=1 SHALL asynchronously force state=IDLE, all counters=0, freq_q=0, dbl_q=0, wash_done=0, water_valve=0, motor_on=0, busy=0.
REQ-031 Reset mid-operation SHALL abandon the cycle with no wash_done pulse.

Configuration
REQ-032 Macro WASHER_DOUBLE_WASH_EN defined: REQ-024 active.
REQ-033 Macro undefined: double_wash port SHALL remain but be ignored; dbl_q tied 0; RINSE always goes to SPIN.

Structure
REQ-034 Package washer_pkg SHALL hold the state typedef/encodings and default duration constants.
REQ-035 Tick generator SHALL be sub-module sec_tick_gen (CLK, RST, freq_q, clear, hold -> sec_tick).

Verification (BASE_CYCLES=4, FILL_T=2, WASH_T=3, RINSE_T=2, SPIN_T=1)
REQ-036 clk_freq=00, coin_in pulse -> FILL 8, WASH 12, RINSE 8, SPIN 4 cycles; wash_done 32 cycles after FILL entry.
REQ-037 clk_freq=11 at coin, changed to 00 mid-WASH -> total 256 cycles, unaffected by the change.
REQ-038 WASHER_DOUBLE_WASH_EN defined, double_wash=1, clk_freq=00 -> states F,W,R,W,R,S; wash_done at 52 cycles; undefined -> 32.
REQ-039 timer_pause high 10 cycles during SPIN -> motor_on=0 for those cycles, wash_done 10 cycles late (42); pause in WASH -> no delay.
REQ-040 RST asserted mid-WASH -> state=IDLE immediately, all outputs 0, no wash_done; coin_in during busy -> no restart.
